// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Multi-cycle instruction-fetch controller. Owns the fetch PC,
//               issues word requests to instruction memory (req/valid) and
//               hands each fetched word to decode (valid/ready). Applies
//               branch redirects and stops fetching permanently after a HLT
//               (opcode 4'hF) has been accepted by decode, until reset.
//
// Ports       : clk          system clock, rising edge
//               rst_n        asynchronous active-low reset
//               imem_req     fetch request to instruction memory
//               imem_addr    fetch address (wired from pc_current)
//               imem_valid   memory returns imem_data this cycle
//               imem_data    instruction word from memory
//               instr_out    registered instruction to decode
//               instr_pc     address of instr_out
//               instr_valid  instr_out / instr_pc valid
//               id_ready     decode accepts when instr_valid & id_ready
//               redirect     PC override this cycle
//               redirect_pc  redirect target (bit 0 forced to 0)
//               pc_current   current fetch PC
//               halted       HLT fetched and accepted; sticky until reset
//
// Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc_current,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [3:0]  C_HLT_OPCODE = 4'hF;
    localparam logic [15:0] C_PC_STEP    = 16'd2;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_drop;
    logic [15:0] r_pending;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_halted;

    state_t      w_state_nxt;
    logic [15:0] w_pc_nxt;
    logic        w_drop_nxt;
    logic [15:0] w_pending_nxt;
    logic [15:0] w_instr_nxt;
    logic [15:0] w_instr_pc_nxt;
    logic        w_instr_valid_nxt;
    logic        w_halted_nxt;

    // Instruction addresses are halfword aligned: the target LSB is dropped.
    logic [15:0] w_redirect_tgt;
    logic [15:0] w_pc_inc;
    logic        w_unused;

    assign w_redirect_tgt = {redirect_pc[15:1], 1'b0};
    assign w_pc_inc       = r_pc + C_PC_STEP;   // carry discarded: 0xFFFE -> 0x0000
    assign w_unused       = redirect_pc[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= 16'h0000;
            r_drop        <= 1'b0;
            r_pending     <= 16'h0000;
            r_instr       <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drop        <= w_drop_nxt;
            r_pending     <= w_pending_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drop_nxt        = r_drop;
        w_pending_nxt     = r_pending;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_halted_nxt      = r_halted;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                if (redirect) begin
                    w_pc_nxt = w_redirect_tgt;
                end
            end

            ST_REQ: begin
                if (imem_valid) begin
                    if (redirect || r_drop) begin
                        // Response belongs to a stale address: throw it away
                        // and restart at the newest known target.
                        w_pc_nxt   = redirect ? w_redirect_tgt : r_pending;
                        w_drop_nxt = 1'b0;
                    end else begin
                        w_instr_nxt       = imem_data;
                        w_instr_pc_nxt    = r_pc;
                        w_instr_valid_nxt = 1'b1;
                        w_state_nxt       = ST_HOLD;
                        if (imem_data[15:12] != C_HLT_OPCODE) begin
                            w_pc_nxt = w_pc_inc;
                        end
                    end
                end else if (redirect) begin
                    // The address must stay stable while the memory is busy,
                    // so the target is parked until the response arrives.
                    w_drop_nxt    = 1'b1;
                    w_pending_nxt = w_redirect_tgt;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    w_instr_valid_nxt = 1'b0;
                    w_pc_nxt          = w_redirect_tgt;
                    w_state_nxt       = ST_REQ;
                end else if (id_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    if (r_instr[15:12] == C_HLT_OPCODE) begin
                        w_state_nxt  = ST_HALT;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end

            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = r_pc;
    assign pc_current  = r_pc;
    assign instr_out   = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire
